// File: rtl/emmc_cmd_responder_if.sv
// CMD-line and decoded-command signal bundle between an eMMC host model and the device responder.
// slave = device side (responder), master = host/environment side.
interface emmc_cmd_responder_if;
    logic        cmd_i;
    logic        cmd_o;
    logic        cmd_oe;
    logic [31:0] resp_status;
    logic        rx_valid;
    logic [5:0]  rx_index;
    logic [31:0] rx_arg;
    logic        crc_err;
    logic        frame_err;

    modport slave (
        input  cmd_i, resp_status,
        output cmd_o, cmd_oe, rx_valid, rx_index, rx_arg, crc_err, frame_err
    );

    modport master (
        output cmd_i, resp_status,
        input  cmd_o, cmd_oe, rx_valid, rx_index, rx_arg, crc_err, frame_err
    );
endinterface

// File: rtl/emmc_cmd_responder.sv
// eMMC device CMD-line responder: receives 48-bit command frames and answers with an R1 frame.
// Latency: rx pulses one cycle after the end bit; response drive starts NCR cycles after the end bit.
// Backpressure: none, the CMD line is free-running; EMMC_CMD_CRC_CHECK_EN enables received-CRC7 rejection.
module emmc_cmd_responder #(
    parameter int NCR = 2
) (
    input  logic                 mclk,
    input  logic                 rstn,
    emmc_cmd_responder_if.slave  bus
);

`ifdef EMMC_CMD_CRC_CHECK_EN
    localparam bit CRC_CHK = 1'b1;
`else
    localparam bit CRC_CHK = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, RX, WAIT, TX} state_t;

    state_t      state, state_nxt;
    logic [5:0]  cnt;
    logic [45:0] rx_sr;
    logic [47:0] tx_sr;
    logic        rx_valid_q, crc_err_q, frame_err_q;
    logic [5:0]  rx_index_q;
    logic [31:0] rx_arg_q;
    logic        end_rx, frame_ok, crc_ok, accept;

    // Serial CRC7, x^7 + x^3 + 1, zero seed, MSB first.
    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            fb = c[6] ^ d[i];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    // rx_sr holds bits 2..47 when the end bit (cmd_i) is being sampled.
    always_comb begin
        end_rx   = (state == RX) && (cnt == 6'd47);
        frame_ok = rx_sr[45] & bus.cmd_i;
        crc_ok   = (crc7({1'b0, rx_sr[45:7]}) == rx_sr[6:0]);
        accept   = frame_ok & (crc_ok | ~CRC_CHK);
    end

    always_ff @(posedge mclk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (!bus.cmd_i) state_nxt = RX;
            RX:   if (cnt == 6'd47)
                      state_nxt = (accept && (rx_sr[44:39] != 6'd0)) ? WAIT : IDLE;
            WAIT: if (cnt == 6'd0) state_nxt = TX;
            TX:   if (cnt == 6'd47) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_oe = (state == TX);
        bus.cmd_o  = (state == TX) ? tx_sr[47] : 1'b1;
    end

    always_ff @(posedge mclk or negedge rstn) begin
        if (!rstn) begin
            cnt   <= 6'd0;
            rx_sr <= '0;
            tx_sr <= '1;
        end else begin
            case (state)
                IDLE: cnt <= 6'd1;
                RX: begin
                    rx_sr <= {rx_sr[44:0], bus.cmd_i};
                    cnt   <= (cnt == 6'd47) ? 6'(NCR - 1) : cnt + 6'd1;
                end
                WAIT: begin
                    if (cnt == 6'd0) begin
                        tx_sr <= {2'b00, rx_index_q, bus.resp_status,
                                  crc7({2'b00, rx_index_q, bus.resp_status}), 1'b1};
                    end else begin
                        cnt <= cnt - 6'd1;
                    end
                end
                TX: begin
                    tx_sr <= {tx_sr[46:0], 1'b1};
                    cnt   <= cnt + 6'd1;
                end
                default: cnt <= 6'd0;
            endcase
        end
    end

    // A bad transmission/end bit masks any CRC failure.
    always_ff @(posedge mclk or negedge rstn) begin
        if (!rstn) begin
            rx_valid_q  <= 1'b0;
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rx_index_q  <= 6'd0;
            rx_arg_q    <= 32'd0;
        end else begin
            rx_valid_q  <= end_rx & accept;
            crc_err_q   <= end_rx & frame_ok & ~crc_ok & CRC_CHK;
            frame_err_q <= end_rx & ~frame_ok;
            if (end_rx && accept) begin
                rx_index_q <= rx_sr[44:39];
                rx_arg_q   <= rx_sr[38:7];
            end
        end
    end

    assign bus.rx_valid  = rx_valid_q;
    assign bus.rx_index  = rx_index_q;
    assign bus.rx_arg    = rx_arg_q;
    assign bus.frame_err = frame_err_q;
`ifdef EMMC_CMD_CRC_CHECK_EN
    assign bus.crc_err   = crc_err_q;
`else
    assign bus.crc_err   = 1'b0;
`endif

endmodule

// File: tb/tb_emmc_cmd_responder.sv
// Scoreboard bench for emmc_cmd_responder: the driver queues expected events, a negedge monitor pops and compares.
module tb_emmc_cmd_responder;
    localparam int NCR = 2;

    // kind: 0 rx_valid, 1 crc_err, 2 frame_err, 3 response frame
    typedef struct {
        int          kind;
        logic [47:0] dat;
        int          cyc;
    } exp_t;

    logic mclk = 1'b0;
    logic rstn = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   oe_cnt = 0;
    exp_t q[$];

    always #5 mclk = ~mclk;
    always @(posedge mclk) cyc <= cyc + 1;

    emmc_cmd_responder_if bus();

    emmc_cmd_responder #(.NCR(NCR)) dut (
        .mclk (mclk),
        .rstn (rstn),
        .bus  (bus)
    );

    // Reference CRC7 by polynomial long division of msg * x^7 by 0x89.
    function automatic logic [6:0] crc_model(input logic [39:0] m);
        logic [46:0] r;
        r = {m, 7'd0};
        for (int i = 46; i >= 7; i--)
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        return r[6:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic pop_cmp(input int kind, input logic [47:0] dat, input int c);
        exp_t e;
        if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_event: actual kind %0d data %0h at cycle %0d, required none", kind, dat, c);
        end else begin
            e = q.pop_front();
            check("event_kind", kind, e.kind);
            check("event_cycle", c, e.cyc);
            check("event_data", dat, e.dat);
        end
    endtask

    // Monitor
    initial begin
        logic [47:0] cap;
        int          cap_n;
        int          cap_start;
        bit          collecting;
        cap = '0; cap_n = 0; cap_start = 0; collecting = 0;
        forever begin
            @(negedge mclk);
            if (!rstn) begin
                collecting = 0;
                cap_n      = 0;
            end else begin
                if (bus.cmd_oe) begin
                    oe_cnt++;
                    if (!collecting) begin
                        collecting = 1;
                        cap_n      = 0;
                        cap_start  = cyc;
                    end
                    cap = {cap[46:0], bus.cmd_o};
                    cap_n++;
                end else begin
                    check("cmd_o_idle_high", bus.cmd_o, 1'b1);
                    if (collecting) begin
                        collecting = 0;
                        check("resp_length", cap_n, 48);
                        pop_cmp(3, cap, cap_start);
                    end
                end
                if (bus.rx_valid)  pop_cmp(0, {10'd0, bus.rx_index, bus.rx_arg}, cyc);
                if (bus.crc_err)   pop_cmp(1, 48'd0, cyc);
                if (bus.frame_err) pop_cmp(2, 48'd0, cyc);
            end
        end
    end

    task automatic send_frame(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc,
                              input logic tbit, input logic ebit, output int c);
        logic [47:0] f;
        f = {1'b0, tbit, idx, arg, crc, ebit};
        for (int i = 47; i >= 0; i--) begin
            @(negedge mclk);
            bus.cmd_i = f[i];
        end
        c = cyc;
    endtask

    // outcome: 0 accept only, 1 accept + R1, 2 crc_err, 3 frame_err; low = cycles cmd_i held 0 after end bit
    task automatic do_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc,
                          input logic tbit, input logic ebit, input int outcome, input int low);
        int          c;
        logic [47:0] r;
        send_frame(idx, arg, crc, tbit, ebit, c);
        case (outcome)
            0: q.push_back('{0, {10'd0, idx, arg}, c + 1});
            1: begin
                q.push_back('{0, {10'd0, idx, arg}, c + 1});
                r = {2'b00, idx, bus.resp_status, crc_model({2'b00, idx, bus.resp_status}), 1'b1};
                q.push_back('{3, r, c + 1 + NCR});
            end
            2: q.push_back('{1, 48'd0, c + 1});
            default: q.push_back('{2, 48'd0, c + 1});
        endcase
        for (int k = 0; k < low; k++) begin
            @(negedge mclk);
            bus.cmd_i = 1'b0;
        end
        @(negedge mclk);
        bus.cmd_i = 1'b1;
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (q.size() != 0 && k < budget) begin
            @(negedge mclk);
            #1;
            k++;
        end
        check("drain_timeout_pending", q.size(), 0);
        q.delete();
    endtask

    task automatic wait_oe(input int budget);
        int k;
        k = 0;
        while (!bus.cmd_oe && k < budget) begin
            @(negedge mclk);
            k++;
        end
        check("cmd_oe_rise_timeout", bus.cmd_oe, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int o;
        bus.cmd_i       = 1'b1;
        bus.resp_status = 32'h0000_0900;
        repeat (3) @(negedge mclk);
        check("rst_cmd_oe", bus.cmd_oe, 1'b0);
        check("rst_cmd_o", bus.cmd_o, 1'b1);
        check("rst_rx_valid", bus.rx_valid, 1'b0);
        check("rst_crc_err", bus.crc_err, 1'b0);
        check("rst_frame_err", bus.frame_err, 1'b0);
        check("rst_rx_index", bus.rx_index, 6'd0);
        check("rst_rx_arg", bus.rx_arg, 32'd0);
        #2 rstn = 1'b1;

        // CMD0: accepted, never answered
        o = oe_cnt;
        do_cmd(6'd0, 32'h0, 7'h4A, 1'b1, 1'b1, 0, 0);
        drain(200);
        repeat (60) @(negedge mclk);
        check("cmd0_no_response", oe_cnt - o, 0);

        // CMD8: R1 answer; status changed after launch must not leak into the frame
        do_cmd(6'd8, 32'h0000_01AA, 7'h43, 1'b1, 1'b1, 1, 0);
        wait_oe(200);
        bus.resp_status = 32'hFFFF_FFFF;
        drain(200);
        check("cmd8_rx_index", bus.rx_index, 6'd8);
        check("cmd8_rx_arg", bus.rx_arg, 32'h0000_01AA);
        bus.resp_status = 32'h0000_0900;

        // CMD8 with corrupted CRC
`ifdef EMMC_CMD_CRC_CHECK_EN
        do_cmd(6'd8, 32'h0000_01AA, 7'h42, 1'b1, 1'b1, 2, 0);
`else
        do_cmd(6'd8, 32'h0000_01AA, 7'h42, 1'b1, 1'b1, 1, 0);
`endif
        drain(200);
        repeat (5) @(negedge mclk);

        // Transmission bit 0 also breaks CRC: frame_err only, registers hold
        do_cmd(6'd5, 32'h1234_5678, 7'h43, 1'b0, 1'b1, 3, 0);
        drain(200);
        check("hold_rx_index", bus.rx_index, 6'd8);
        check("hold_rx_arg", bus.rx_arg, 32'h0000_01AA);

        // CMD0 with end bit 0, then a good CMD0
        do_cmd(6'd0, 32'h0, 7'h4A, 1'b1, 1'b0, 3, 0);
        drain(200);
        do_cmd(6'd0, 32'h0, 7'h4A, 1'b1, 1'b1, 0, 0);
        drain(200);
        check("cmd0_rx_index", bus.rx_index, 6'd0);

        // Reset at TX bit 20 of a CMD8 response
        do_cmd(6'd8, 32'h0000_01AA, 7'h43, 1'b1, 1'b1, 0, 0);
        wait_oe(200);
        repeat (19) @(negedge mclk);
        #2 rstn = 1'b0;
        #1;
        check("mid_tx_rst_cmd_oe", bus.cmd_oe, 1'b0);
        check("mid_tx_rst_cmd_o", bus.cmd_o, 1'b1);
        check("mid_tx_rst_rx_index", bus.rx_index, 6'd0);
        drain(50);
        @(negedge mclk);
        @(negedge mclk);
        #2 rstn = 1'b1;
        o = oe_cnt;
        repeat (60) @(negedge mclk);
        check("post_rst_no_response", oe_cnt - o, 0);
        do_cmd(6'd0, 32'h0, 7'h4A, 1'b1, 1'b1, 0, 0);
        drain(200);

        // cmd_i low through WAIT, then back-to-back CMD8 frames
        bus.resp_status = 32'h0000_0920;
        do_cmd(6'd8, 32'h0000_01AA, 7'h43, 1'b1, 1'b1, 1, NCR);
        drain(200);
        do_cmd(6'd8, 32'h0000_01AA, 7'h43, 1'b1, 1'b1, 1, NCR);
        drain(200);
        repeat (20) @(negedge mclk);
        check("final_queue_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
